// File: rtl/psram_bus_bridge.sv
// psram_bus_bridge
//   Bridges a valid/ready CPU word bus with byte strobes onto the single-cycle
//   strobe / busy / done protocol of the 32-bit QPI PSRAM controller.
//   Partial-word writes become a read-modify-write pair because the controller
//   only writes whole words. A per-access watchdog turns a missing done into an
//   error response.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_valid / o_ready      CPU request handshake (accept = i_valid & o_ready)
//   i_we, i_addr, i_wdata, i_wstrb   request fields (addr[1:0] ignored)
//   o_ack, o_err, o_rdata  one-cycle response; o_err flags a watchdog timeout
//   o_psr_*                controller request (stb, we, addr, din)
//   i_psr_dout/busy/done   controller response
module psram_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [23:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        o_ack,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_psr_stb,
  output logic        o_psr_we,
  output logic [23:0] o_psr_addr,
  output logic [31:0] o_psr_din,
  input  logic [31:0] i_psr_dout,
  input  logic        i_psr_busy,
  input  logic        i_psr_done
);

  typedef enum logic [2:0] {
    IDLE, RESP, ISSUE_RD, ISSUE_WR, WAIT_RD, WAIT_WR
  } state_t;

  state_t      state;
  logic        we_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [15:0] tcnt;
  logic [31:0] merged;
  logic        accept;
  logic        timeout_hit;

  // Combinational so the CPU sees the controller's busy (including its long
  // post-reset init) without an extra cycle of latency.
  assign o_ready     = (state == IDLE) & ~i_psr_busy & ~i_rst;
  assign accept      = i_valid & o_ready;
  assign timeout_hit = (tcnt == 16'(TIMEOUT_CYCLES - 1));

  // Byte merge of the CPU write data over the word just read back.
  always_comb begin
    merged = '0;
    for (int n = 0; n < 4; n++)
      merged[8*n +: 8] = wstrb_q[n] ? wdata_q[8*n +: 8] : i_psr_dout[8*n +: 8];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      tcnt       <= '0;
      o_ack      <= 1'b0;
      o_err      <= 1'b0;
      o_rdata    <= '0;
      o_psr_stb  <= 1'b0;
      o_psr_we   <= 1'b0;
      o_psr_addr <= '0;
      o_psr_din  <= '0;
    end else begin
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_psr_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q       <= i_we;
            wstrb_q    <= i_wstrb;
            wdata_q    <= i_wdata;
            o_psr_addr <= {i_addr[23:2], 2'b00};
            if (!i_we)
              state <= ISSUE_RD;
            else if (i_wstrb == 4'hF) begin
              o_psr_din <= i_wdata;
              state     <= ISSUE_WR;
            end else if (i_wstrb == 4'h0)
              state <= RESP;
            else
              state <= ISSUE_RD;   // partial write: fetch the old word first
          end
        end
        RESP: begin
          o_ack <= 1'b1;
          state <= IDLE;
        end
        ISSUE_RD: begin
          if (!i_psr_busy) begin
            o_psr_stb <= 1'b1;
            o_psr_we  <= 1'b0;
            tcnt      <= '0;
            state     <= WAIT_RD;
          end
        end
        ISSUE_WR: begin
          if (!i_psr_busy) begin
            o_psr_stb <= 1'b1;
            o_psr_we  <= 1'b1;
            tcnt      <= '0;
            state     <= WAIT_WR;
          end
        end
        // addr/din stay untouched while waiting: the controller samples din
        // late in the write burst.
        WAIT_RD: begin
          if (i_psr_done) begin
            if (we_q) begin
              o_psr_din <= merged;
              state     <= ISSUE_WR;
            end else begin
              o_rdata <= i_psr_dout;
              o_ack   <= 1'b1;
              state   <= IDLE;
            end
          end else if (timeout_hit) begin
            o_ack <= 1'b1;
            o_err <= 1'b1;
            state <= IDLE;           // abandons any pending RMW write
          end else
            tcnt <= tcnt + 16'd1;
        end
        WAIT_WR: begin
          if (i_psr_done) begin
            o_ack <= 1'b1;
            state <= IDLE;
          end else if (timeout_hit) begin
            o_ack <= 1'b1;
            o_err <= 1'b1;
            state <= IDLE;
          end else
            tcnt <= tcnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_bus_bridge.sv
// Bench for psram_bus_bridge: a controller model (init busy, fixed read/write
// latencies, optional hang) plus a scoreboard of expected responses.
module tb_psram_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic        we = 1'b0;
  logic [23:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ack, err;
  logic [31:0] rdata;
  logic        psr_stb, psr_we;
  logic [23:0] psr_addr;
  logic [31:0] psr_din;
  logic [31:0] psr_dout = '0;
  logic        psr_busy = 1'b1;
  logic        psr_done = 1'b0;

  psram_bus_bridge #(.TIMEOUT_CYCLES(255)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_we(we), .i_addr(addr), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_ack(ack), .o_err(err), .o_rdata(rdata),
    .o_psr_stb(psr_stb), .o_psr_we(psr_we), .o_psr_addr(psr_addr),
    .o_psr_din(psr_din), .i_psr_dout(psr_dout), .i_psr_busy(psr_busy),
    .i_psr_done(psr_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // ---------------- controller model ----------------
  bit [31:0]   mem [int];
  int          init_len = 20000;
  int          init_left = 0;
  bit          hang = 0;
  bit          op_active = 0;
  int          op_cnt = 0;
  bit          op_we = 0;
  int          op_addr = 0;
  logic [31:0] op_din = '0;
  int          din_bad = 0;

  always @(posedge clk) begin
    if (rst) begin
      psr_busy  <= 1'b1;
      psr_done  <= 1'b0;
      init_left <= init_len;
      op_active <= 0;
    end else begin
      psr_done <= 1'b0;
      if (init_left != 0) begin
        if (init_left == 1) psr_busy <= 1'b0;
        init_left <= init_left - 1;
      end else if (op_active) begin
        if (op_cnt == 1) begin
          psr_done  <= 1'b1;
          psr_busy  <= 1'b0;
          op_active <= 0;
          if (op_we) begin
            mem[op_addr] = psr_din;          // din sampled late, as the controller does
            if (psr_din !== op_din) din_bad = din_bad + 1;
          end else
            psr_dout <= mem.exists(op_addr) ? mem[op_addr] : 32'h0;
        end else
          op_cnt <= op_cnt - 1;
      end else if (psr_stb && !hang) begin
        psr_busy  <= 1'b1;
        op_active <= 1;
        op_cnt    <= psr_we ? 12 : 19;
        op_we     <= psr_we;
        op_addr   <= int'(psr_addr[23:2]);
        op_din    <= psr_din;
      end
    end
  end

  // ---------------- monitors ----------------
  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rd;
    bit          chk;
  } exp_t;
  exp_t sbq[$];

  int          stb_cnt = 0;
  logic [23:0] stb_addr = '0;
  logic        stb_we = 1'b0;
  int          ready_bad = 0;
  int          stb_busy_bad = 0;

  always @(negedge clk) begin
    if (psr_stb === 1'b1) begin
      stb_cnt  = stb_cnt + 1;
      stb_addr = psr_addr;
      stb_we   = psr_we;
      if (psr_busy === 1'b1) stb_busy_bad = stb_busy_bad + 1;
    end
    if (!rst && psr_busy === 1'b1 && ready === 1'b1) ready_bad = ready_bad + 1;
    if (ack === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_ack at cyc %0d got ack=1 required 0", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        total++;
        assert (cyc === e.cyc) else begin
          bad++; $error("FAIL ack_cycle got %0d required %0d", cyc, e.cyc);
        end
        total++;
        assert (err === e.err) else begin
          bad++; $error("FAIL ack_err got %b required %b", err, e.err);
        end
        if (e.chk) begin
          total++;
          assert (rdata === e.rd) else begin
            bad++; $error("FAIL ack_rdata got %h required %h", rdata, e.rd);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic req(input bit sync, input logic w, input logic [23:0] a,
                     input logic [31:0] d, input logic [3:0] s, input int lat,
                     input logic e, input logic [31:0] rd, input bit chk,
                     input bit push);
    int guard = 0;
    if (sync) @(negedge clk);
    valid = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
    while (ready !== 1'b1 && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    total++;
    assert (ready === 1'b1) else begin
      bad++; $error("FAIL accept_wait got ready=%b required 1", ready);
    end
    @(posedge clk);
    #1;
    if (push) sbq.push_back('{cyc + lat, e, rd, chk});
    valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sbq.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    total++;
    assert (sbq.size() == 0) else begin
      bad++; $error("FAIL drain got pending=%0d required 0", sbq.size());
    end
  endtask

  task automatic wait_init();
    int guard = 0;
    @(negedge clk);
    while (psr_busy === 1'b1 && guard < 30000) begin
      @(negedge clk);
      guard++;
    end
    total++;
    assert (ready === 1'b1) else begin
      bad++; $error("FAIL ready_after_init got %b required 1", ready);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] req_v);
    total++;
    assert (got === req_v) else begin
      bad++; $error("FAIL %s got %h required %h", tag, got, req_v);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (4) @(negedge clk);
    chk32("reset_outputs",
          {6'b0, ack, err, psr_stb, psr_we, ready, 1'b0, psr_addr},
          32'h0);
    chk32("reset_rdata", rdata, 32'h0);
    chk32("reset_din", psr_din, 32'h0);

    // init gating: controller busy for init_len cycles after reset
    rst = 1'b0;
    wait_init();

    // full-word write
    stb_cnt = 0;
    req(1, 1'b1, 24'h000104, 32'hDEADBEEF, 4'hF, 15, 1'b0, 32'h0, 0, 1);
    drain();
    chk32("wr_stb_cnt", stb_cnt, 1);
    chk32("wr_stb_we", {31'b0, stb_we}, 32'h1);
    chk32("wr_stb_addr", {8'h0, stb_addr}, 32'h000104);
    chk32("wr_mem", mem[32'h41], 32'hDEADBEEF);

    // read, unaligned byte address
    mem[32'h41] = 32'h12345678;
    stb_cnt = 0;
    req(1, 1'b0, 24'h000107, 32'h0, 4'h0, 22, 1'b0, 32'h12345678, 1, 1);
    drain();
    chk32("rd_stb_cnt", stb_cnt, 1);
    chk32("rd_stb_we", {31'b0, stb_we}, 32'h0);
    chk32("rd_stb_addr", {8'h0, stb_addr}, 32'h000104);

    // partial write -> read-modify-write
    mem[32'h80] = 32'hAABBCCDD;
    stb_cnt = 0;
    req(1, 1'b1, 24'h000200, 32'h11223344, 4'b0101, 37, 1'b0, 32'h0, 0, 1);
    drain();
    chk32("rmw_stb_cnt", stb_cnt, 2);
    chk32("rmw_mem", mem[32'h80], 32'hAA22CC44);

    // zero-strobe write, read presented in its ack cycle
    stb_cnt = 0;
    req(1, 1'b1, 24'h000300, 32'hFFFFFFFF, 4'h0, 1, 1'b0, 32'h0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk32("b2b_ack_ready", {30'b0, ack, ready}, 32'h3);
    req(0, 1'b0, 24'h000200, 32'h0, 4'h0, 22, 1'b0, 32'hAA22CC44, 1, 1);
    drain();
    chk32("zero_stb_cnt", stb_cnt, 1);
    chk32("zero_mem", mem.exists(32'hC0) ? mem[32'hC0] : 32'h0, 32'h0);

    // watchdog: controller never answers; rdata must keep previous value
    hang = 1;
    req(1, 1'b0, 24'h000104, 32'h0, 4'h0, 256, 1'b1, 32'hAA22CC44, 1, 1);
    drain();
    hang = 0;

    // reset in the middle of a read: no ack, everything back to zero
    init_len = 100;
    req(1, 1'b0, 24'h000104, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk32("midrst_ctl", {26'b0, ack, err, psr_stb, psr_we, ready, 1'b0}, 32'h0);
    chk32("midrst_addr", {8'h0, psr_addr}, 32'h0);
    chk32("midrst_din", psr_din, 32'h0);
    chk32("midrst_rdata", rdata, 32'h0);
    rst = 1'b0;
    wait_init();
    req(1, 1'b0, 24'h000104, 32'h0, 4'h0, 22, 1'b0, 32'h12345678, 1, 1);
    drain();

    // protocol invariants across the whole run
    chk32("ready_while_busy", ready_bad, 0);
    chk32("stb_while_busy", stb_busy_bad, 0);
    chk32("din_stable", din_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psram_bus_bridge.md
Name: psram_bus_bridge

Overview:
- CPU-side bridge sitting directly upstream of the 32-bit QPI PSRAM controller (`psram`).
- Converts a valid/ready word bus with byte strobes into the controller's single-cycle strobe / busy / done protocol.
- Partial-word writes become read-modify-write sequences, since the controller only writes full 32-bit words.
- Adds a per-transaction watchdog that reports an error response if the controller never signals done.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent waiting for i_psr_done per controller access before aborting with o_err; valid range 1..65535.

Ports:
- i_clk  in  1  clock; same 100 MHz clock as the PSRAM controller.
- i_rst  in  1  synchronous, active-high reset; shared with the PSRAM controller.
- i_valid  in  1  CPU request valid.
- o_ready  out  1  bridge can accept a request this cycle.
- i_we  in  1  1 = write, 0 = read.
- i_addr  in  24  CPU byte address; bits [1:0] ignored (word access).
- i_wdata  in  32  write data.
- i_wstrb  in  4  byte enables; bit n covers data bits [8n+7:8n].
- o_ack  out  1  one-cycle response pulse.
- o_err  out  1  valid with o_ack; 1 = watchdog timeout.
- o_rdata  out  32  read data; valid with o_ack on reads.
- o_psr_stb  out  1  to controller i_stb.
- o_psr_we  out  1  to controller i_we.
- o_psr_addr  out  24  to controller i_addr.
- o_psr_din  out  32  to controller i_din.
- i_psr_dout  in  32  from controller o_dout.
- i_psr_busy  in  1  from controller o_busy.
- i_psr_done  in  1  from controller o_done.

Behaviour:
- Reset values: all registered outputs 0 (o_ack, o_err, o_rdata, o_psr_stb, o_psr_we, o_psr_addr, o_psr_din); state IDLE.
- o_ready is combinational: (state==IDLE) & ~i_psr_busy & ~i_rst. It therefore stays low through the controller's ~20000-cycle post-reset init.
- Accept occurs when i_valid & o_ready at a clock edge. On accept, latch we, wstrb and wdata, and set o_psr_addr = {i_addr[23:2], 2'b00}.
- Routing after accept:
  - Read: go to ISSUE_RD.
  - Write with wstrb == 4'hF: set o_psr_din = wdata, go to ISSUE_WR.
  - Write with wstrb == 4'h0: no PSRAM access; RESP on the next edge (o_ack=1, o_err=0).
  - Any other write (partial): go to ISSUE_RD, then MERGE.
- ISSUE_RD / ISSUE_WR:
  - When ~i_psr_busy, drive o_psr_stb=1 for exactly one cycle and set o_psr_we to 0 or 1 respectively.
  - Clear the timeout counter and go to WAIT_RD / WAIT_WR.
  - o_psr_stb is never high while i_psr_busy is high.
- WAIT_RD / WAIT_WR: o_psr_stb=0; o_psr_addr and o_psr_din are held stable, because the controller samples i_din late in the write.
- On the edge that samples i_psr_done=1:
  - WAIT_RD for a plain read: o_rdata = i_psr_dout, o_ack=1, go to IDLE.
  - WAIT_RD for a partial write (merge done at this same edge): o_psr_din[8n+7:8n] = wstrb[n] ? wdata byte n : i_psr_dout byte n; go to ISSUE_WR. No o_ack yet.
  - WAIT_WR: o_ack=1, go to IDLE.
- Timeout: the counter increments each WAIT cycle without done. On reaching TIMEOUT_CYCLES: o_ack=1, o_err=1, o_rdata unchanged, go to IDLE, abandoning any RMW write phase.
- o_ack and o_err are high for exactly one cycle. o_err is 0 on every non-timeout ack. o_rdata holds its value until the next successful read.
- Back-to-back: o_ready may be high during the o_ack cycle, so a new request can be accepted then.
- Reset mid-operation: return to IDLE immediately with no o_ack; all outputs take their reset values.
- i_psr_done arriving outside a WAIT state is ignored.
- Nominal latency (controller idle, accept at edge E0; o_ack high in the cycle after the stated edge):
  - full write: ack at E15.
  - read: ack at E22.
  - partial write: ack at E37.
  - wstrb == 0 write: ack at E1.

Test Plan:
- Init gating: assert i_rst, then release with a controller model holding i_psr_busy=1 for 20000 cycles -> o_ready=0 throughout; o_ready=1 the cycle busy falls.
- Full write: addr 24'h000104, wdata 32'hDEADBEEF, wstrb F -> single o_psr_stb with we=1, o_psr_addr=24'h000104; o_psr_din stable until done; o_ack at E15 with o_err=0.
- Read: read 24'h000107 from a model returning 32'h12345678 -> o_psr_addr=24'h000104, we=0; o_rdata=32'h12345678 with o_ack at E22.
- RMW: memory word 32'hAABBCCDD, write wdata 32'h11223344 with wstrb 4'b0101 -> read then write; written word 32'hAA22CC44; exactly one o_ack, at E37.
- Zero strobe, back-to-back, and error:
  - Write with wstrb 0 -> no o_psr_stb, o_ack at E1.
  - A read presented during that ack cycle is accepted.
  - Model that never raises done -> o_ack with o_err=1 after 255 wait cycles.
- Reset mid-read: pulse i_rst during WAIT_RD -> no o_ack; all outputs 0; the next read after busy falls completes normally.
